// File: rtl/opb_slave_xfer_mux.sv
// opb_slave_xfer_mux: shares one OPB slave attachment between NUM_SLV register slaves.
// Decodes the address window and drives a registered one-hot downstream select.
// Returns the selected slave's data and ack as single-cycle, zero-when-idle outputs.
// Optional feature macro: OPB_MUX_TIMEOUT_EN enables the WAIT-state watchdog that
// raises an error acknowledge when the selected slave stays silent.
module opb_slave_xfer_mux #(
    parameter logic [31:0] C_BASEADDR = 32'h01000000,
    parameter int unsigned NUM_SLV    = 4,
    parameter int unsigned SLV_AW     = 8,
    parameter int unsigned TIMEOUT    = 12
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:31]               OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [NUM_SLV-1:0]        slv_select,
    input  logic [32*NUM_SLV-1:0]     slv_DBus,
    input  logic [NUM_SLV-1:0]        slv_xferAck,
    input  logic [NUM_SLV-1:0]        slv_errAck,
    input  logic [NUM_SLV-1:0]        slv_toutSup
);

    localparam int unsigned IdxW  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [32:0] WinLo = {1'b0, C_BASEADDR};
    localparam logic [32:0] WinHi = WinLo + (33'(NUM_SLV) << SLV_AW);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StRecover} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [NUM_SLV-1:0]   sel_q, sel_d;
    logic [31:0]          dbus_q, dbus_d;
    logic                 xfer_q, xfer_d;
    logic                 err_q, err_d;
    logic                 tsup_q, tsup_d;
`ifdef OPB_MUX_TIMEOUT_EN
    logic [3:0]           cnt_q, cnt_d;
`endif

    // Byte-enables and write data go straight to the register bank; seqAddr is ignored.
    logic unused_inputs;
    assign unused_inputs = ^{OPB_BE, OPB_DBus, OPB_seqAddr};

    // Address value with LSB-0 numbering (bus bit 0 is the MSB).
    logic [31:0] addr;
    logic [3:0]  addr_idx;
    logic        in_range;
    logic [IdxW-1:0] dec_idx;

    assign addr     = OPB_ABus;
    assign addr_idx = addr[SLV_AW+3:SLV_AW];
    // Index bound guards against a base that is not aligned to the 16-slave field.
    assign in_range = ({1'b0, addr} >= WinLo) && ({1'b0, addr} < WinHi) &&
                      (32'(addr_idx) < NUM_SLV);
    assign dec_idx  = addr_idx[IdxW-1:0];

    // Per-slave read words, slave i at bits [32i+31:32i].
    logic [31:0] slv_word [NUM_SLV];
    for (genvar i = 0; i < NUM_SLV; i++) begin : g_word
        assign slv_word[i] = slv_DBus[32*i +: 32];
    end

    logic cur_ack, cur_xfer, cur_err, cur_tsup;
    assign cur_xfer = slv_xferAck[idx_q];
    assign cur_err  = slv_errAck[idx_q];
    assign cur_ack  = cur_xfer | cur_err;
    assign cur_tsup = slv_toutSup[idx_q];

    // Next-state and registered-output logic; acks and data default to zero.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        dbus_d  = '0;
        xfer_d  = 1'b0;
        err_d   = 1'b0;
        tsup_d  = 1'b0;
`ifdef OPB_MUX_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (OPB_select && in_range) begin
                    state_d        = StWait;
                    idx_d          = dec_idx;
                    sel_d          = '0;
                    sel_d[dec_idx] = 1'b1;
`ifdef OPB_MUX_TIMEOUT_EN
                    cnt_d          = '0;
`endif
                end
            end
            StWait: begin
                tsup_d = cur_tsup;
                if (!OPB_select) begin
                    // Master abort beats any same-cycle slave ack.
                    state_d = StIdle;
                    sel_d   = '0;
                end else if (cur_ack) begin
                    state_d = StAck;
                    sel_d   = '0;
                    xfer_d  = cur_xfer;
                    err_d   = cur_err & ~cur_xfer;
                    dbus_d  = OPB_RNW ? slv_word[idx_q] : 32'h0;
                end
`ifdef OPB_MUX_TIMEOUT_EN
                else if (!cur_tsup) begin
                    if (cnt_q == 4'(TIMEOUT - 1)) begin
                        state_d = StAck;
                        sel_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`endif
            end
            StAck: begin
                state_d = StRecover;
            end
            StRecover: begin
                // Dead cycle so a still-high select is not decoded twice.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            sel_q   <= '0;
            dbus_q  <= '0;
            xfer_q  <= 1'b0;
            err_q   <= 1'b0;
            tsup_q  <= 1'b0;
`ifdef OPB_MUX_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            dbus_q  <= dbus_d;
            xfer_q  <= xfer_d;
            err_q   <= err_d;
            tsup_q  <= tsup_d;
`ifdef OPB_MUX_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = xfer_q;
    assign Sl_errAck  = err_q;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = tsup_q;
    assign slv_select = sel_q;

endmodule

// File: tb/tb_opb_slave_xfer_mux.sv
// Scoreboard bench for opb_slave_xfer_mux with default parameters.
// Stimulus pushes expected acknowledges; a negedge monitor pops and checks them.
module tb_opb_slave_xfer_mux;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:31]   abus;
    logic [0:3]    be;
    logic [0:31]   wdbus;
    logic          rnw;
    logic          sel;
    logic          seq;
    logic [0:31]   sl_dbus;
    logic          sl_xfer, sl_err, sl_retry, sl_tsup;
    logic [3:0]    slv_sel;
    logic [127:0]  slv_dbus;
    logic [3:0]    slv_xfer, slv_err, slv_tsup;

    opb_slave_xfer_mux dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (wdbus),
        .OPB_RNW     (rnw),
        .OPB_select  (sel),
        .OPB_seqAddr (seq),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (sl_xfer),
        .Sl_errAck   (sl_err),
        .Sl_retry    (sl_retry),
        .Sl_toutSup  (sl_tsup),
        .slv_select  (slv_sel),
        .slv_DBus    (slv_dbus),
        .slv_xferAck (slv_xfer),
        .slv_errAck  (slv_err),
        .slv_toutSup (slv_tsup)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        xfer;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [31:0] a, input logic r, input logic [31:0] wd);
        abus  = a;
        rnw   = r;
        wdbus = wd;
        sel   = 1'b1;
        t0    = cyc;
    endtask

    task automatic expect_ack(input int k, input logic x, input logic e, input logic [31:0] d);
        exp_t it;
        it.cyc  = t0 + k;
        it.xfer = x;
        it.err  = e;
        it.data = d;
        q.push_back(it);
    endtask

    // Monitor: every acknowledge must match the head of the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (sl_xfer || sl_err) begin
            if (q.size() == 0) begin
                chk("spurious_ack", {30'b0, sl_xfer, sl_err}, 32'h0);
            end else begin
                e = q.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("xferAck", 32'(sl_xfer), 32'(e.xfer));
                chk("errAck", 32'(sl_err), 32'(e.err));
                chk("ack_data", sl_dbus, e.data);
            end
        end else if (sl_dbus != 32'h0) begin
            chk("idle_dbus", sl_dbus, 32'h0);
        end
        if (sl_retry !== 1'b0) chk("retry", 32'(sl_retry), 32'h0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        abus     = '0;
        be       = 4'hF;
        wdbus    = '0;
        rnw      = 1'b1;
        sel      = 1'b0;
        seq      = 1'b0;
        slv_dbus = '0;
        slv_xfer = '0;
        slv_err  = '0;
        slv_tsup = '0;
        #3;
        chk("rst_select", 32'(slv_sel), 32'h0);
        chk("rst_xfer", 32'(sl_xfer), 32'h0);
        chk("rst_err", 32'(sl_err), 32'h0);
        chk("rst_tsup", 32'(sl_tsup), 32'h0);
        chk("rst_dbus", sl_dbus, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Read slave 2, ack in cycle 3.
        issue(32'h01000204, 1'b1, 32'h0);
        step();
        chk("t1_sel_c1", 32'(slv_sel), 32'h4);
        step();
        chk("t1_sel_c2", 32'(slv_sel), 32'h4);
        step();
        chk("t1_sel_c3", 32'(slv_sel), 32'h4);
        slv_xfer[2]           = 1'b1;
        slv_dbus[64 +: 32]    = 32'hDEADBEEF;
        expect_ack(4, 1'b1, 1'b0, 32'hDEADBEEF);
        step();
        slv_xfer = '0;
        sel      = 1'b0;
        chk("t1_sel_c4", 32'(slv_sel), 32'h0);
        idle(3);

        // Write slave 3, ack in cycle 1; write returns zero data.
        issue(32'h01000300, 1'b0, 32'h12345678);
        step();
        chk("t2_sel_c1", 32'(slv_sel), 32'h8);
        slv_xfer[3]        = 1'b1;
        slv_dbus[96 +: 32] = 32'hFFFFFFFF;
        expect_ack(2, 1'b1, 1'b0, 32'h0);
        step();
        slv_xfer = '0;
        sel      = 1'b0;
        chk("t2_sel_c2", 32'(slv_sel), 32'h0);
        idle(3);

        // Out-of-range address is never decoded.
        issue(32'h01000400, 1'b1, 32'h0);
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("t3_sel_oor", 32'(slv_sel), 32'h0);
        end
        sel = 1'b0;
        idle(2);

        // Slave 1 silent.
        issue(32'h01000100, 1'b1, 32'h0);
`ifdef OPB_MUX_TIMEOUT_EN
        expect_ack(13, 1'b0, 1'b1, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            step();
            chk("t4_sel_wait", 32'(slv_sel), 32'h2);
        end
        step();
        chk("t4_sel_c13", 32'(slv_sel), 32'h0);
        sel = 1'b0;
`else
        for (int c = 1; c <= 30; c++) begin
            step();
            chk("t4_sel_wait", 32'(slv_sel), 32'h2);
        end
        sel = 1'b0;
        step();
        chk("t4_sel_abort", 32'(slv_sel), 32'h0);
`endif
        idle(3);

        // Slave 0 suppresses timeout for cycles 1-30, acks in cycle 31.
        issue(32'h01000010, 1'b1, 32'h0);
        slv_dbus[0 +: 32] = 32'hA5A5A5A5;
        for (int c = 1; c <= 32; c++) begin
            step();
            chk("t5_toutSup", 32'(sl_tsup), 32'((c >= 2) && (c <= 31)));
            if (c == 1) slv_tsup[0] = 1'b1;
            if (c <= 31) chk("t5_sel", 32'(slv_sel), 32'h1);
            if (c == 31) begin
                slv_tsup[0] = 1'b0;
                slv_xfer[0] = 1'b1;
                expect_ack(32, 1'b1, 1'b0, 32'hA5A5A5A5);
            end
            if (c == 32) begin
                slv_xfer = '0;
                sel      = 1'b0;
            end
        end
        idle(3);

        // Abort in cycle 2 with a same-cycle slave ack: no acknowledge upstream.
        issue(32'h01000120, 1'b1, 32'h0);
        idle(2);
        sel         = 1'b0;
        slv_xfer[1] = 1'b1;
        step();
        slv_xfer = '0;
        chk("t6_sel_abort", 32'(slv_sel), 32'h0);
        idle(3);

        // Slave asserts both acks: xferAck wins and carries the data.
        issue(32'h01000300, 1'b1, 32'h0);
        step();
        slv_xfer[3]        = 1'b1;
        slv_err[3]         = 1'b1;
        slv_dbus[96 +: 32] = 32'h0000CAFE;
        expect_ack(2, 1'b1, 1'b0, 32'h0000CAFE);
        step();
        slv_xfer = '0;
        slv_err  = '0;
        sel      = 1'b0;
        idle(3);

        // Slave error acknowledge only.
        issue(32'h01000000, 1'b1, 32'h0);
        step();
        slv_err[0]        = 1'b1;
        slv_dbus[0 +: 32] = 32'h11111111;
        expect_ack(2, 1'b0, 1'b1, 32'h11111111);
        step();
        slv_err = '0;
        sel     = 1'b0;
        idle(3);

        // Reset asserted in cycle 5 of a WAIT with toutSup high.
        issue(32'h01000200, 1'b1, 32'h0);
        step();
        slv_tsup[2] = 1'b1;
        idle(4);
        chk("t7_sel_pre", 32'(slv_sel), 32'h4);
        chk("t7_tsup_pre", 32'(sl_tsup), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t7_sel_rst", 32'(slv_sel), 32'h0);
        chk("t7_tsup_rst", 32'(sl_tsup), 32'h0);
        chk("t7_xfer_rst", 32'(sl_xfer), 32'h0);
        chk("t7_err_rst", 32'(sl_err), 32'h0);
        chk("t7_dbus_rst", sl_dbus, 32'h0);
        sel      = 1'b0;
        slv_tsup = '0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        issue(32'h01000000, 1'b1, 32'h0);
        step();
        chk("t7_sel_after", 32'(slv_sel), 32'h1);
        slv_xfer[0]       = 1'b1;
        slv_dbus[0 +: 32] = 32'h0BADF00D;
        expect_ack(2, 1'b1, 1'b0, 32'h0BADF00D);
        step();
        slv_xfer = '0;
        sel      = 1'b0;
        idle(4);

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
